// File: rtl/child_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : child_dispatch_pkg
// Brief    : Shared FSM states, response status encodings and defaults for
//            child_dispatch_seq (optional timeout: CHILD_DISPATCH_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
package child_dispatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD_IDX = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int DEFAULT_NUM_CHILD = 5;

endpackage : child_dispatch_pkg
`default_nettype wire

// File: rtl/child_dispatch_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : child_dispatch_seq_if
// Brief    : Request / child / response signal bundle for child_dispatch_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface child_dispatch_seq_if
  import child_dispatch_pkg::*;
#(
  parameter int NUM_CHILD = DEFAULT_NUM_CHILD
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_idx;
  logic [NUM_CHILD-1:0] child_start;
  logic [NUM_CHILD-1:0] child_done;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2:0]           rsp_idx;
  logic [1:0]           rsp_status;
  logic                 busy;

  // master: requester plus the child slots; slave: the dispatcher
  modport master (
    output req_valid, req_idx, child_done, rsp_ready,
    input  req_ready, child_start, rsp_valid, rsp_idx, rsp_status, busy
  );

  modport slave (
    input  req_valid, req_idx, child_done, rsp_ready,
    output req_ready, child_start, rsp_valid, rsp_idx, rsp_status, busy
  );

endinterface : child_dispatch_seq_if
`default_nettype wire

// File: rtl/child_dispatch_tmo.sv
`default_nettype none
// ============================================================================
// Module   : child_dispatch_tmo
// Brief    : WAIT-cycle counter; expired flags the last permitted WAIT cycle.
//            Only instantiated when CHILD_DISPATCH_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module child_dispatch_tmo #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam logic [7:0] c_limit = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 8'd1;
    end
  end

  // r_count holds the number of completed WAIT cycles, so equality with
  // TIMEOUT_CYCLES-1 marks the final allowed cycle
  assign expired = enable && (r_count == c_limit);

endmodule : child_dispatch_tmo
`default_nettype wire

// File: rtl/child_dispatch_seq.sv
`default_nettype none
// ============================================================================
// Module   : child_dispatch_seq
// Brief    : Dispatches one request at a time to a child slot, waits for its
//            done level and returns a status. Optional WAIT timeout enabled by
//            defining CHILD_DISPATCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module child_dispatch_seq
  import child_dispatch_pkg::*;
#(
  parameter int NUM_CHILD      = DEFAULT_NUM_CHILD,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  child_dispatch_seq_if.slave bus
);

  localparam logic [3:0] c_num_child = 4'(NUM_CHILD);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_idx;
  logic [1:0]           r_rsp_status;
  logic [1:0]           w_rsp_status;
  logic                 w_accept;
  logic                 w_rsp_load;
  logic                 w_idx_ok;
  logic                 w_done;
  logic [NUM_CHILD-1:0] w_sel;

  for (genvar g = 0; g < NUM_CHILD; g++) begin : g_sel
    assign w_sel[g] = (r_idx == 3'(g));
  end

  // only the latched slot's done counts; other slots are masked off
  assign w_done   = |(bus.child_done & w_sel);
  assign w_idx_ok = ({1'b0, bus.req_idx} < c_num_child);

`ifdef CHILD_DISPATCH_TIMEOUT_EN
  logic w_tmo_expired;

  child_dispatch_tmo #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (r_state != S_WAIT),
    .enable  (r_state == S_WAIT),
    .expired (w_tmo_expired)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_rsp_status <= ST_OK;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx <= bus.req_idx;
      end
      if (w_rsp_load) begin
        r_rsp_status <= w_rsp_status;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_rsp_load   = 1'b0;
    w_rsp_status = ST_OK;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (w_idx_ok) begin
            w_state_nxt = S_START;
          end else begin
            w_state_nxt  = S_RESP;
            w_rsp_load   = 1'b1;
            w_rsp_status = ST_BAD_IDX;
          end
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a coinciding timeout
        if (w_done) begin
          w_state_nxt  = S_RESP;
          w_rsp_load   = 1'b1;
          w_rsp_status = ST_OK;
        end
`ifdef CHILD_DISPATCH_TIMEOUT_EN
        else if (w_tmo_expired) begin
          w_state_nxt  = S_RESP;
          w_rsp_load   = 1'b1;
          w_rsp_status = ST_TIMEOUT;
        end
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.child_start = (r_state == S_START) ? w_sel : '0;
  assign bus.rsp_idx     = r_idx;
  assign bus.rsp_status  = r_rsp_status;

endmodule : child_dispatch_seq
`default_nettype wire

// File: tb/tb_child_dispatch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_child_dispatch_seq
// Brief    : Directed and randomized checks of child_dispatch_seq against a
//            cycle-level reference model (honours CHILD_DISPATCH_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_child_dispatch_seq;
  import child_dispatch_pkg::*;

  localparam int NUM_CHILD = 5;
  localparam int TMO       = 16;
`ifdef CHILD_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  child_dispatch_seq_if #(.NUM_CHILD(NUM_CHILD)) bus ();

  child_dispatch_seq #(
    .NUM_CHILD      (NUM_CHILD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle k is the interval after the k-th rising edge following the cycle in
  // which req_valid is presented. done_at: target done is high from cycle
  // 1+done_at onward. hold: RESP cycles with rsp_ready low.
  task automatic run_req(input logic [2:0] idx, input int done_at, input int hold, input bit noise);
    int                   exp_r;
    int                   d;
    bit                   good;
    logic [1:0]           exp_st;
    logic [NUM_CHILD-1:0] sel;
    logic [NUM_CHILD-1:0] exp_start;
    string                t;

    good = (int'(idx) < NUM_CHILD);
    for (int i = 0; i < NUM_CHILD; i++) sel[i] = good && (i == int'(idx));

    // reference: START in cycle 1, WAIT from cycle 2, RESP the cycle after done
    if (!good) begin
      exp_r  = 1;
      exp_st = ST_BAD_IDX;
    end else begin
      d = (1 + done_at < 2) ? 2 : 1 + done_at;
      if (TO_EN && d > 1 + TMO) begin
        exp_r  = 2 + TMO;
        exp_st = ST_TIMEOUT;
      end else begin
        exp_r  = d + 1;
        exp_st = ST_OK;
      end
    end

    @(negedge clk);
    t = $sformatf("req_ready_idle idx=%0d", idx);
    chk(t, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_idx    = idx;
    bus.child_done = '0;
    bus.rsp_ready  = 1'b0;

    for (int k = 1; k <= exp_r + hold + 1; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      exp_start = (good && k == 1) ? sel : '0;
      t = $sformatf("idx=%0d k=%0d", idx, k);
      chk({"child_start ", t}, 32'(bus.child_start), 32'(exp_start));
      chk({"rsp_valid ", t}, 32'(bus.rsp_valid), 32'(k >= exp_r && k <= exp_r + hold));
      chk({"busy ", t}, 32'(bus.busy), 32'(k <= exp_r + hold));
      chk({"req_ready ", t}, 32'(bus.req_ready), 32'(k > exp_r + hold));
      if (k >= exp_r && k <= exp_r + hold) begin
        chk({"rsp_idx ", t}, 32'(bus.rsp_idx), 32'(idx));
        chk({"rsp_status ", t}, 32'(bus.rsp_status), 32'(exp_st));
      end
      bus.rsp_ready  = (k >= exp_r + hold);
      bus.child_done = noise ? (NUM_CHILD'($urandom) & ~sel) : '0;
      if (good && k >= 1 + done_at) bus.child_done = bus.child_done | sel;
    end
    bus.rsp_ready  = 1'b0;
    bus.child_done = '0;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_idx    = '0;
    bus.child_done = '0;
    bus.rsp_ready  = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst child_start", 32'(bus.child_start), 32'd0);
    chk("rst rsp_idx", 32'(bus.rsp_idx), 32'd0);
    chk("rst rsp_status", 32'(bus.rsp_status), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst req_ready", 32'(bus.req_ready), 32'd1);

    run_req(3'd2, 4, 0, 1'b0);    // done[2] four cycles after start
    run_req(3'd6, 0, 0, 1'b0);    // bad index
    run_req(3'd0, 40, 0, 1'b1);   // done beyond the timeout window
    run_req(3'd3, 16, 0, 1'b0);   // done on the last WAIT cycle
    run_req(3'd4, 1, 10, 1'b1);   // consumer stalls the response
    run_req(3'd1, 8, 0, 1'b1);    // foreign done bits while idx=1 waits
    run_req(3'd5, 0, 0, 1'b0);    // first out-of-range index
    run_req(3'd4, 0, 0, 1'b0);    // done already high during START

    for (int n = 0; n < 20; n++) begin
      run_req(3'($urandom_range(0, 7)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    // reset in the middle of START
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_idx   = 3'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_rst start_before", 32'(bus.child_start), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst start_drop", 32'(bus.child_start), 32'd0);
    chk("mid_rst busy", 32'(bus.busy), 32'd0);
    chk("mid_rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_rst req_ready", 32'(bus.req_ready), 32'd1);
      chk("after_rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("after_rst child_start", 32'(bus.child_start), 32'd0);
    end
    run_req(3'd0, 2, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_child_dispatch_seq
`default_nettype wire
